sample_fifo: RTL and testbench
==============================

Name: sample_fifo

Overview:
Synchronous single-clock sample FIFO that buffers DATAWIDTH-bit signed samples from the sample source (ADC capture or DDS) ahead of the 2^SAMPLE_RATE linear-interpolation upsampler.
- Produces the above_half flag that the upsampler uses as its start/enable input.
- Serves one-cycle rd_en pulses from the upsampler (one pulse per 2^SAMPLE_RATE output clocks).
- Reports overflow/underflow so rate mismatches are visible in debug.

Parameters:
DATAWIDTH, 14, sample width in bits (two's complement; FIFO treats it as opaque).
ADDR_WIDTH, 6, log2 of depth; DEPTH = 2^ADDR_WIDTH = 64 entries.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
wr_en  input  1  write strobe; accepted only when not full.
wr_data  input  DATAWIDTH  sample to write.
rd_en  input  1  read strobe from upsampler; accepted only when not empty.
rd_data  output  DATAWIDTH  registered read data.
rd_valid  output  1  one-cycle pulse, high the cycle rd_data updates.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
above_half  output  1  count >= DEPTH/2.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky; set on write attempt while full.
underflow  output  1  sticky; set on read attempt while empty.

Behaviour:
- Reset: rst high at a clk edge clears:
  - pointers, count, rd_data (=0), rd_valid (=0), overflow/underflow (=0)
  - full=0, empty=1, above_half=0
  - RAM contents are not cleared
  - reset mid-stream discards all stored samples; first post-reset write lands at address 0
- Pointers: ADDR_WIDTH-bit wr_ptr/rd_ptr wrap naturally DEPTH-1 -> 0; occupancy tracked in a separate count register (no pointer-MSB trick).
- Write: wr_en && !full -> mem[wr_ptr] <= wr_data, wr_ptr++.
- Read: rd_en && !empty -> rd_data <= mem[rd_ptr] at that edge, rd_ptr++, rd_valid=1 next cycle.
  - read latency is 1 clk: rd_data valid the cycle after the rd_en cycle
  - rd_data holds its value until the next accepted read
- Count update per edge:
  - +1 on an accepted write only
  - -1 on an accepted read only
  - unchanged on both or neither
- Simultaneous write and read:
  - empty: write accepted, read rejected (underflow set), count 0 -> 1
  - full: both accepted (the read frees a slot the same edge), count stays DEPTH, overflow NOT set
  - otherwise: both accepted
- Flags full, empty, above_half are registered, derived from the next-state count, so they are exact in the cycle after the update.
- overflow/underflow are sticky until rst; rejected operations leave memory, pointers and rd_data untouched.
- Write-to-read latency: a sample written at edge N into an empty FIFO is readable with rd_en at edge N+1 (empty falls after edge N).
- No first-word fall-through; no almost-full/empty thresholds beyond above_half.

Decomposition:
- Shared package adda_pkg: DATAWIDTH default (14) and SAMPLE_RATE default (4), shared with the upsampler so widths stay consistent.
- One sub-module: sample_fifo_ram, a simple dual-port RAM (one write port, one registered read port, DEPTH x DATAWIDTH) so it infers block/distributed RAM.
- All pointer, count and flag logic stays in sample_fifo.

Test Plan:
1. Reset then idle -> empty=1, full=0, above_half=0, count=0, rd_data=0, rd_valid=0, overflow=underflow=0.
2. Write 0x0001..0x0020 (32 writes) -> above_half rises the cycle after the 32nd write; count=32. Then 32 single rd_en pulses spaced 16 clk apart -> rd_data=0x0001..0x0020 in order, each valid one cycle after its rd_en with rd_valid pulse.
3. Write 64 samples (0x3FFF down to 0x3FC0) -> full=1, count=64. 65th write -> overflow=1, count stays 64. Read all 64 -> 0x3FFF first, 0x3FC0 last, empty=1.
4. Fill to 64 with wrap: pre-advance pointers by writing/reading 40 samples, then fill 64 with simultaneous wr_en/rd_en for 10 cycles -> count stays 64, overflow=0, output order unbroken across the 63->0 address wrap.
5. On empty FIFO assert rd_en alone -> underflow=1, rd_data unchanged, rd_valid=0. Then rd_en and wr_en (0x1234) together -> write accepted, count=1; next rd_en returns 0x1234.
6. Fill to 40, assert rst for 1 cycle while wr_en/rd_en active -> next cycle count=0, empty=1, flags cleared. First post-reset write 0x0AAA read back as 0x0AAA.

Source files
------------

// File: rtl/adda_pkg.sv
// rtl/adda_pkg.sv - widths shared between sample capture, FIFO and upsampler
package adda_pkg;
   localparam int DATAWIDTH   = 14;
   localparam int SAMPLE_RATE = 4;
   localparam int ADDR_WIDTH  = 6;
endpackage

// File: rtl/sample_fifo_if.sv
// rtl/sample_fifo_if.sv - sample FIFO write/read/status bundle
interface sample_fifo_if #(
   parameter int DATAWIDTH  = adda_pkg::DATAWIDTH,
   parameter int ADDR_WIDTH = adda_pkg::ADDR_WIDTH
);
   logic                  wr_en;
   logic [DATAWIDTH-1:0]  wr_data;
   logic                  rd_en;
   logic [DATAWIDTH-1:0]  rd_data;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  above_half;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, full, empty, above_half, count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output rd_data, rd_valid, full, empty, above_half, count, overflow, underflow
   );
endinterface

// File: rtl/sample_fifo_ram.sv
// rtl/sample_fifo_ram.sv - simple dual-port RAM, one write port, registered read port
module sample_fifo_ram #(
   parameter int DATAWIDTH  = adda_pkg::DATAWIDTH,
   parameter int ADDR_WIDTH = adda_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATAWIDTH-1:0]  wr_data,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATAWIDTH-1:0]  rd_data
);
   logic [DATAWIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
   end

   // Same-address read and write return the old word, which the full-FIFO read+write case relies on.
   always_ff @(posedge clk) begin
      if (rst)
         rd_data <= '0;
      else if (re)
         rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - single-clock sample FIFO feeding the linear-interpolation upsampler
module sample_fifo #(
   parameter int DATAWIDTH  = adda_pkg::DATAWIDTH,
   parameter int ADDR_WIDTH = adda_pkg::ADDR_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   sample_fifo_if.slave    bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] HALF_C  = (ADDR_WIDTH+1)'(DEPTH/2);

   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]   count_q, count_next;
   logic                  full_q, empty_q, above_half_q;
   logic                  overflow_q, underflow_q, rd_valid_q;
   logic                  wr_accept, rd_accept;

   // A write while full still succeeds when a read frees the slot on the same edge.
   always_comb begin
      rd_accept  = bus.rd_en && !empty_q;
      wr_accept  = bus.wr_en && (!full_q || bus.rd_en);
      count_next = count_q;
      if (wr_accept && !rd_accept)
         count_next = count_q + 1'b1;
      else if (rd_accept && !wr_accept)
         count_next = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         above_half_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         rd_valid_q   <= 1'b0;
      end else begin
         if (wr_accept)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_accept)
            rd_ptr <= rd_ptr + 1'b1;
         count_q      <= count_next;
         full_q       <= (count_next == DEPTH_C);
         empty_q      <= (count_next == '0);
         above_half_q <= (count_next >= HALF_C);
         rd_valid_q   <= rd_accept;
         if (bus.wr_en && full_q && !bus.rd_en)
            overflow_q <= 1'b1;
         if (bus.rd_en && empty_q)
            underflow_q <= 1'b1;
      end
   end

   sample_fifo_ram #(
      .DATAWIDTH  (DATAWIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_accept && !rst),
      .wr_addr (wr_ptr),
      .wr_data (bus.wr_data),
      .re      (rd_accept),
      .rd_addr (rd_ptr),
      .rd_data (bus.rd_data)
   );

   assign bus.rd_valid   = rd_valid_q;
   assign bus.full       = full_q;
   assign bus.empty      = empty_q;
   assign bus.above_half = above_half_q;
   assign bus.count      = count_q;
   assign bus.overflow   = overflow_q;
   assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_sample_fifo.sv
// tb/tb_sample_fifo.sv - scoreboard bench for sample_fifo
module tb_sample_fifo;
   localparam int DW    = 14;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sample_fifo_if bus();
   sample_fifo dut (.clk(clk), .rst(rst), .bus(bus));

   logic [DW-1:0] model[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_q = '0;
   logic [DW-1:0] exp_v;
   bit pend, armed, ovf_m, unf_m;
   int checks = 0;
   int failures = 0;

   // Advance one edge and update the reference model from the inputs held across it.
   task automatic step();
      int n;
      n = model.size();
      @(posedge clk);
      if (rst) begin
         model.delete(); exp_q.delete();
         ovf_m = 0; unf_m = 0; pend = 0; last_q = '0; armed = 1;
      end else begin
         if (bus.rd_en && n == 0) unf_m = 1;
         if (bus.wr_en && n == DEPTH && !bus.rd_en) ovf_m = 1;
         pend = bus.rd_en && n > 0;
         if (pend) exp_q.push_back(model.pop_front());
         if (bus.wr_en && (n < DEPTH || bus.rd_en)) model.push_back(bus.wr_data);
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (armed) begin
         checks++;
         if (bus.rd_valid !== pend) begin
            failures++; $display("FAIL rd_valid got=%b exp=%b t=%0t", bus.rd_valid, pend, $time);
         end
         if (pend && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.rd_data !== exp_v) begin
               failures++; $display("FAIL rd_data got=%h exp=%h t=%0t", bus.rd_data, exp_v, $time);
            end
            last_q = exp_v;
         end else begin
            checks++;
            if (bus.rd_data !== last_q) begin
               failures++; $display("FAIL rd_data_hold got=%h exp=%h t=%0t", bus.rd_data, last_q, $time);
            end
         end
         pend = 0;
         checks++;
         if ({bus.full, bus.empty, bus.above_half, bus.count, bus.overflow, bus.underflow} !==
             {model.size() == DEPTH, model.size() == 0, model.size() >= DEPTH/2, 7'(model.size()), ovf_m, unf_m}) begin
            failures++;
            $display("FAIL status got=f%b e%b h%b c%0d o%b u%b exp_count=%0d o%b u%b t=%0t",
                     bus.full, bus.empty, bus.above_half, bus.count, bus.overflow, bus.underflow,
                     model.size(), ovf_m, unf_m, $time);
         end
      end
   end

   task automatic test_reset();
      bus.wr_en = 0; bus.rd_en = 0; bus.wr_data = '0;
      rst = 1; step(); rst = 0; step();
      checks++;
      if ({bus.full, bus.empty, bus.above_half, bus.count} !== {3'b010, 7'd0}) begin
         failures++; $display("FAIL reset_flags got=%b%b%b c%0d exp=010 c0", bus.full, bus.empty, bus.above_half, bus.count);
      end
      checks++;
      if ({bus.rd_data, bus.rd_valid, bus.overflow, bus.underflow} !== {14'h0, 3'b000}) begin
         failures++; $display("FAIL reset_out got=%h v%b o%b u%b exp=0000 v0 o0 u0", bus.rd_data, bus.rd_valid, bus.overflow, bus.underflow);
      end
   endtask

   task automatic test_half();
      for (int i = 1; i <= 32; i++) begin
         bus.wr_en = 1; bus.wr_data = 14'(i); step();
         if (i == 31) begin
            checks++;
            if (bus.above_half !== 1'b0) begin failures++; $display("FAIL half_31 got=%b exp=0", bus.above_half); end
         end
      end
      bus.wr_en = 0;
      checks++;
      if (bus.above_half !== 1'b1 || bus.count !== 7'd32) begin
         failures++; $display("FAIL half_32 got=h%b c%0d exp=h1 c32", bus.above_half, bus.count);
      end
      for (int i = 1; i <= 32; i++) begin
         bus.rd_en = 1; step(); bus.rd_en = 0;
         checks++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== 14'(i)) begin
            failures++; $display("FAIL half_read got=v%b %h exp=v1 %h", bus.rd_valid, bus.rd_data, 14'(i));
         end
         repeat (15) step();
      end
   endtask

   task automatic test_full_overflow();
      for (int i = 0; i < 64; i++) begin
         bus.wr_en = 1; bus.wr_data = 14'(16'h3FFF - i); step();
      end
      checks++;
      if (bus.full !== 1'b1 || bus.count !== 7'd64) begin
         failures++; $display("FAIL full got=f%b c%0d exp=f1 c64", bus.full, bus.count);
      end
      bus.wr_data = 14'h1111; step(); bus.wr_en = 0;
      checks++;
      if (bus.overflow !== 1'b1 || bus.count !== 7'd64) begin
         failures++; $display("FAIL overflow got=o%b c%0d exp=o1 c64", bus.overflow, bus.count);
      end
      bus.rd_en = 1;
      for (int i = 0; i < 64; i++) step();
      bus.rd_en = 0;
      checks++;
      if (bus.rd_data !== 14'h3FC0 || bus.empty !== 1'b1) begin
         failures++; $display("FAIL drain got=%h e%b exp=3fc0 e1", bus.rd_data, bus.empty);
      end
      step();
   endtask

   task automatic test_wrap();
      rst = 1; step(); rst = 0;
      for (int i = 0; i < 40; i++) begin bus.wr_en = 1; bus.wr_data = 14'(16'h0040 + i); step(); end
      bus.wr_en = 0; bus.rd_en = 1;
      for (int i = 0; i < 40; i++) step();
      bus.rd_en = 0;
      for (int i = 0; i < 64; i++) begin bus.wr_en = 1; bus.wr_data = 14'(16'h0100 + i); step(); end
      bus.rd_en = 1;
      for (int i = 0; i < 10; i++) begin
         bus.wr_data = 14'(16'h0200 + i); step();
         checks++;
         if (bus.count !== 7'd64 || bus.overflow !== 1'b0) begin
            failures++; $display("FAIL wrap_full got=c%0d o%b exp=c64 o0", bus.count, bus.overflow);
         end
      end
      bus.wr_en = 0;
      for (int i = 0; i < 64; i++) step();
      bus.rd_en = 0;
      checks++;
      if (bus.rd_data !== 14'h0209 || bus.empty !== 1'b1) begin
         failures++; $display("FAIL wrap_last got=%h e%b exp=0209 e1", bus.rd_data, bus.empty);
      end
      step();
   endtask

   task automatic test_underflow();
      rst = 1; step(); rst = 0;
      bus.rd_en = 1; step();
      checks++;
      if (bus.underflow !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_data !== 14'h0) begin
         failures++; $display("FAIL underflow got=u%b v%b %h exp=u1 v0 0000", bus.underflow, bus.rd_valid, bus.rd_data);
      end
      bus.wr_en = 1; bus.wr_data = 14'h1234; step(); bus.wr_en = 0;
      checks++;
      if (bus.count !== 7'd1 || bus.rd_valid !== 1'b0) begin
         failures++; $display("FAIL empty_rw got=c%0d v%b exp=c1 v0", bus.count, bus.rd_valid);
      end
      step(); bus.rd_en = 0;
      checks++;
      if (bus.rd_data !== 14'h1234 || bus.rd_valid !== 1'b1) begin
         failures++; $display("FAIL empty_rw_read got=%h v%b exp=1234 v1", bus.rd_data, bus.rd_valid);
      end
      step();
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 40; i++) begin bus.wr_en = 1; bus.wr_data = 14'(16'h0500 + i); step(); end
      bus.rd_en = 1; rst = 1; step();
      rst = 0; bus.wr_en = 0; bus.rd_en = 0; step();
      checks++;
      if ({bus.full, bus.empty, bus.above_half, bus.count, bus.overflow, bus.underflow, bus.rd_valid} !== {3'b010, 7'd0, 3'b000}) begin
         failures++; $display("FAIL midreset got=f%b e%b h%b c%0d o%b u%b v%b exp=e1 rest 0",
                              bus.full, bus.empty, bus.above_half, bus.count, bus.overflow, bus.underflow, bus.rd_valid);
      end
      bus.wr_en = 1; bus.wr_data = 14'h0AAA; step(); bus.wr_en = 0;
      bus.rd_en = 1; step(); bus.rd_en = 0;
      checks++;
      if (bus.rd_data !== 14'h0AAA) begin
         failures++; $display("FAIL post_reset_read got=%h exp=0aaa", bus.rd_data);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_half();
      test_full_overflow();
      test_wrap();
      test_underflow();
      test_reset_midstream();
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
